// File: rtl/bp_cce_pkg.sv
// bp_cce_pkg: CCE-local types, including the sharers generator FSM states
package bp_cce_pkg;
  typedef enum logic [1:0] {
    e_idle,
    e_read,
    e_done
  } bp_cce_dir_sharers_gen_state_e;
endpackage

// File: rtl/bp_common_pkg.sv
// bp_common_pkg: coherence state encoding shared by the CCE and LCE sides
package bp_common_pkg;
  typedef enum logic [2:0] {
    e_COH_I = 3'b000,
    e_COH_S = 3'b001,
    e_COH_E = 3'b010,
    e_COH_F = 3'b011,
    e_COH_M = 3'b110,
    e_COH_O = 3'b111
  } bp_coh_states_e;
endpackage

// File: rtl/bp_cce_dir_sharers_gen_matcher.sv
// bp_cce_dir_sharers_gen_matcher: per-LCE tag match over all ways, lowest hitting way wins
module bp_cce_dir_sharers_gen_matcher
  import bp_common_pkg::*;
#(
  parameter int lce_assoc_p = 8,
  parameter int tag_width_p = 12,
  localparam int lg_lce_assoc_lp = (lce_assoc_p == 1) ? 1 : $clog2(lce_assoc_p),
  localparam int state_w_lp = $bits(bp_coh_states_e),
  localparam int entry_w_lp = tag_width_p + state_w_lp
) (
  input  logic [tag_width_p-1:0]             tag_i,
  input  logic [lce_assoc_p*entry_w_lp-1:0]  entries_i,
  output logic                               hit_o,
  output logic [lg_lce_assoc_lp-1:0]         way_o,
  output bp_coh_states_e                     state_o
);
  logic [lce_assoc_p-1:0] way_hit;
  bp_coh_states_e way_state [lce_assoc_p];
  logic [lg_lce_assoc_lp-1:0] pe_way;
  logic pe_v;
  for (genvar w = 0; w < lce_assoc_p; w++) begin : g_way
    assign way_state[w] = bp_coh_states_e'(entries_i[w*entry_w_lp +: state_w_lp]);
    assign way_hit[w] = (entries_i[w*entry_w_lp+state_w_lp +: tag_width_p] == tag_i) && (way_state[w] != e_COH_I);
  end
  bsg_priority_encode #(.width_p(lce_assoc_p), .lo_to_hi_p(1)) u_pe (
    .i(way_hit),
    .addr_o(pe_way),
    .v_o(pe_v)
  );
  assign hit_o = pe_v;
  assign way_o = pe_v ? pe_way : '0;
  assign state_o = pe_v ? way_state[pe_way] : e_COH_I;
endmodule

// File: rtl/bsg_priority_encode.sv
// bsg_priority_encode: index of the lowest (lo_to_hi_p) or highest set bit, v_o when any bit set
module bsg_priority_encode #(
  parameter int width_p = 8,
  parameter int lo_to_hi_p = 1,
  localparam int lg_width_lp = (width_p == 1) ? 1 : $clog2(width_p)
) (
  input  logic [width_p-1:0]     i,
  output logic [lg_width_lp-1:0] addr_o,
  output logic                   v_o
);
  assign v_o = |i;
  always_comb begin
    addr_o = '0;
    for (int k = 0; k < width_p; k++)
      if (i[(lo_to_hi_p != 0) ? width_p-1-k : k]) addr_o = lg_width_lp'((lo_to_hi_p != 0) ? width_p-1-k : k);
  end
endmodule

// File: rtl/bp_cce_dir_sharers_gen.sv
// bp_cce_dir_sharers_gen: scans a way-group's directory rows and builds per-LCE sharers hit/way/state vectors
module bp_cce_dir_sharers_gen
  import bp_common_pkg::*;
  import bp_cce_pkg::*;
#(
  parameter int num_lce_p = 4,
  parameter int lce_assoc_p = 8,
  parameter int lce_per_row_p = 2,
  parameter int tag_width_p = 12,
  parameter int wg_width_p = 4,
  localparam int rows_lp = num_lce_p / lce_per_row_p,
  localparam int lg_lce_assoc_lp = (lce_assoc_p == 1) ? 1 : $clog2(lce_assoc_p),
  localparam int lg_rows_lp = (rows_lp == 1) ? 1 : $clog2(rows_lp),
  localparam int ram_addr_width_lp = wg_width_p + lg_rows_lp,
  localparam int state_w_lp = $bits(bp_coh_states_e),
  localparam int lce_w_lp = lce_assoc_p * (tag_width_p + state_w_lp)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   v_i,
  output logic                                   ready_o,
  input  logic [wg_width_p-1:0]                  wg_i,
  input  logic [tag_width_p-1:0]                 tag_i,
  output logic                                   ram_v_o,
  output logic [ram_addr_width_lp-1:0]           ram_addr_o,
  input  logic [lce_per_row_p*lce_w_lp-1:0]      ram_data_i,
  output logic                                   sharers_v_o,
  output logic [num_lce_p-1:0]                   sharers_hits_o,
  output logic [num_lce_p*lg_lce_assoc_lp-1:0]   sharers_ways_o,
  output logic [num_lce_p*state_w_lp-1:0]        sharers_coh_states_o
);
  localparam logic [lg_rows_lp-1:0] last_row_lp = lg_rows_lp'(rows_lp - 1);
  bp_cce_dir_sharers_gen_state_e state_q;
  logic [wg_width_p-1:0] wg_q;
  logic [tag_width_p-1:0] tag_q;
  logic [lg_rows_lp-1:0] row_q, data_row_q;
  logic ram_v_q, data_v_q, sharers_v_q;
  logic [num_lce_p-1:0] hits_q, hits_n;
  logic [num_lce_p*lg_lce_assoc_lp-1:0] ways_q, ways_n;
  logic [num_lce_p*state_w_lp-1:0] states_q, states_n;
  logic [lce_per_row_p-1:0] m_hit;
  logic [lg_lce_assoc_lp-1:0] m_way [lce_per_row_p];
  bp_coh_states_e m_state [lce_per_row_p];
  for (genvar l = 0; l < lce_per_row_p; l++) begin : g_match
    bp_cce_dir_sharers_gen_matcher #(.lce_assoc_p(lce_assoc_p), .tag_width_p(tag_width_p)) u_match (
      .tag_i(tag_q),
      .entries_i(ram_data_i[l*lce_w_lp +: lce_w_lp]),
      .hit_o(m_hit[l]),
      .way_o(m_way[l]),
      .state_o(m_state[l])
    );
  end
  for (genvar n = 0; n < num_lce_p; n++) begin : g_lce
    localparam int slot_lp = n % lce_per_row_p;
    logic sel;
    assign sel = data_v_q && (data_row_q == lg_rows_lp'(n / lce_per_row_p));
    assign hits_n[n] = sel ? m_hit[slot_lp] : hits_q[n];
    assign ways_n[n*lg_lce_assoc_lp +: lg_lce_assoc_lp] = sel ? m_way[slot_lp] : ways_q[n*lg_lce_assoc_lp +: lg_lce_assoc_lp];
    assign states_n[n*state_w_lp +: state_w_lp] = sel ? m_state[slot_lp] : states_q[n*state_w_lp +: state_w_lp];
  end
  assign ready_o = state_q != e_read;
  assign ram_v_o = ram_v_q;
  assign ram_addr_o = {wg_q, row_q};
  assign sharers_v_o = sharers_v_q;
  assign sharers_hits_o = hits_q;
  assign sharers_ways_o = ways_q;
  assign sharers_coh_states_o = states_q;
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= e_idle;
      wg_q <= '0;
      tag_q <= '0;
      row_q <= '0;
      data_row_q <= '0;
      ram_v_q <= 1'b0;
      data_v_q <= 1'b0;
      sharers_v_q <= 1'b0;
      hits_q <= '0;
      ways_q <= '0;
      states_q <= '0;
    end else begin
      data_v_q <= ram_v_q;
      data_row_q <= row_q;
      if (v_i && ready_o) begin
        state_q <= e_read;
        wg_q <= wg_i;
        tag_q <= tag_i;
        row_q <= '0;
        ram_v_q <= 1'b1;
        sharers_v_q <= 1'b0;
        hits_q <= '0;
        ways_q <= '0;
        states_q <= '0;
      end else if (state_q == e_read) begin
        if (ram_v_q) begin
          ram_v_q <= row_q != last_row_lp;
          row_q <= (row_q == last_row_lp) ? row_q : row_q + 1'b1;
        end
        if (data_v_q) begin
          hits_q <= hits_n;
          ways_q <= ways_n;
          states_q <= states_n;
          if (data_row_q == last_row_lp) begin
            state_q <= e_done;
            sharers_v_q <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_bp_cce_dir_sharers_gen.sv
// tb_bp_cce_dir_sharers_gen: directed and randomized checks of the sharers generator against a directory model
module tb_bp_cce_dir_sharers_gen;
  logic clk = 1'b0;
  logic reset_i = 1'b0;
  logic v_i = 1'b0;
  logic [3:0] wg_i = '0;
  logic [11:0] tag_i = '0;
  logic [239:0] ram_data_i = '0;
  logic ready_o, ram_v_o, sharers_v_o;
  logic [4:0] ram_addr_o;
  logic [3:0] hits;
  logic [11:0] ways, states;
  logic [239:0] mem [32];
  logic [11:0] cur_tag = '0;
  logic pv = 1'b0;
  logic [4:0] pa = '0;
  logic [2:0] st_tab [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
  int vectors = 0;
  int miscompares = 0;

  bp_cce_dir_sharers_gen dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o),
    .wg_i(wg_i), .tag_i(tag_i), .ram_v_o(ram_v_o), .ram_addr_o(ram_addr_o),
    .ram_data_i(ram_data_i), .sharers_v_o(sharers_v_o), .sharers_hits_o(hits),
    .sharers_ways_o(ways), .sharers_coh_states_o(states)
  );

  always #5 clk = ~clk;

  // RAM responder: returns the addressed row one cycle after a strobe, otherwise
  // drives rows that would hit the current tag in state M if wrongly captured.
  always @(negedge clk) begin
    pv = ram_v_o;
    pa = ram_addr_o;
  end
  always @(posedge clk) begin
    #1;
    if (pv) ram_data_i = mem[pa];
    else for (int e = 0; e < 16; e++) ram_data_i[e*15 +: 15] = {cur_tag, 3'd6};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_invalid();
    for (int a = 0; a < 32; a++)
      for (int e = 0; e < 16; e++) mem[a][e*15 +: 15] = {12'($urandom), 3'd0};
  endtask

  task automatic set_entry(input int addr, input int slot, input int way, input logic [11:0] tg, input logic [2:0] st);
    mem[addr][(slot*8+way)*15 +: 15] = {tg, st};
  endtask

  task automatic randomize_wg(input int wg, input logic [11:0] tag);
    for (int r = 0; r < 2; r++)
      for (int e = 0; e < 16; e++)
        mem[wg*2+r][e*15 +: 15] = {($urandom_range(0, 2) == 0) ? tag : 12'($urandom), st_tab[$urandom_range(0, 5)]};
  endtask

  // Reference: LCE n lives in row n/2, slot n%2; first valid matching way wins.
  task automatic model(input int wg, input logic [11:0] tag, output logic [3:0] h, output logic [11:0] wy, output logic [11:0] st);
    h = '0;
    wy = '0;
    st = '0;
    for (int n = 0; n < 4; n++) begin
      logic found;
      logic [14:0] ent;
      found = 1'b0;
      for (int w = 0; w < 8; w++) begin
        ent = mem[wg*2 + n/2][((n%2)*8 + w)*15 +: 15];
        if (!found && ent[14:3] == tag && ent[2:0] != 3'd0) begin
          found = 1'b1;
          h[n] = 1'b1;
          wy[n*3 +: 3] = 3'(w);
          st[n*3 +: 3] = ent[2:0];
        end
      end
    end
  endtask

  task automatic issue(input logic [3:0] wg, input logic [11:0] tag);
    wg_i = wg;
    tag_i = tag;
    cur_tag = tag;
    v_i = 1'b1;
    step();
    v_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b0;
    step();
    step();
    vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b exp 1", ready_o); end
    vectors++; if (ram_v_o !== 1'b0) begin miscompares++; $display("FAIL reset_ram_v got %b exp 0", ram_v_o); end
    vectors++; if (ram_addr_o !== 5'h00) begin miscompares++; $display("FAIL reset_addr got %h exp 00", ram_addr_o); end
    vectors++; if ({sharers_v_o, hits, ways, states} !== 29'h0) begin miscompares++; $display("FAIL reset_sharers got v=%b h=%b w=%h s=%h exp all 0", sharers_v_o, hits, ways, states); end
    reset_i = 1'b1;
  endtask

  task automatic test_single_hit();
    fill_invalid();
    set_entry(5'h0A, 1, 3, 12'h01A, 3'd1);
    issue(4'd5, 12'h01A);
    vectors++; if ({ready_o, ram_v_o, sharers_v_o} !== 3'b010) begin miscompares++; $display("FAIL single_c1_ctl got rdy/rv/sv=%b%b%b exp 010", ready_o, ram_v_o, sharers_v_o); end
    vectors++; if (ram_addr_o !== 5'h0A) begin miscompares++; $display("FAIL single_addr0 got %h exp 0a", ram_addr_o); end
    step();
    vectors++; if ({ram_v_o, ram_addr_o} !== {1'b1, 5'h0B}) begin miscompares++; $display("FAIL single_addr1 got v=%b a=%h exp v=1 a=0b", ram_v_o, ram_addr_o); end
    step();
    vectors++; if ({ready_o, ram_v_o, sharers_v_o} !== 3'b000) begin miscompares++; $display("FAIL single_c3_ctl got rdy/rv/sv=%b%b%b exp 000", ready_o, ram_v_o, sharers_v_o); end
    step();
    vectors++; if ({ready_o, sharers_v_o} !== 2'b11) begin miscompares++; $display("FAIL single_c4_valid got rdy=%b sv=%b exp 11", ready_o, sharers_v_o); end
    vectors++; if ({hits, ways, states} !== {4'b0010, 12'h018, 12'h008}) begin miscompares++; $display("FAIL single_result got h=%b w=%h s=%h exp h=0010 w=018 s=008", hits, ways, states); end
  endtask

  task automatic test_multi_hit();
    fill_invalid();
    set_entry(2*7+1, 0, 0, 12'h01A, 3'd0);
    set_entry(2*7+1, 0, 2, 12'h01A, 3'd6);
    set_entry(2*7+1, 0, 6, 12'h01A, 3'd1);
    issue(4'd7, 12'h01A);
    repeat (3) step();
    vectors++; if ({sharers_v_o, hits, ways, states} !== {1'b1, 4'b0100, 12'h080, 12'h180}) begin miscompares++; $display("FAIL multi_result got v=%b h=%b w=%h s=%h exp v=1 h=0100 w=080 s=180", sharers_v_o, hits, ways, states); end
  endtask

  task automatic test_invalid();
    for (int a = 0; a < 32; a++)
      for (int e = 0; e < 16; e++) mem[a][e*15 +: 15] = {12'h01A, 3'd0};
    issue(4'd2, 12'h01A);
    repeat (3) step();
    vectors++; if ({sharers_v_o, hits, ways, states} !== {1'b1, 28'h0}) begin miscompares++; $display("FAIL invalid_result got v=%b h=%b w=%h s=%h exp v=1 rest 0", sharers_v_o, hits, ways, states); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ha, hb;
    logic [11:0] wa, wb, sa, sb;
    randomize_wg(3, 12'h155);
    randomize_wg(9, 12'h2AA);
    set_entry(3*2, 0, 4, 12'h155, 3'd2);
    set_entry(9*2+1, 1, 1, 12'h2AA, 3'd7);
    model(3, 12'h155, ha, wa, sa);
    model(9, 12'h2AA, hb, wb, sb);
    issue(4'd3, 12'h155);
    wg_i = 4'd9;
    tag_i = 12'h2AA;
    v_i = 1'b1;
    vectors++; if (ready_o !== 1'b0) begin miscompares++; $display("FAIL b2b_busy got ready=%b exp 0", ready_o); end
    step();
    step();
    vectors++; if (ram_addr_o !== 5'h07) begin miscompares++; $display("FAIL b2b_ignored got addr=%h exp 07", ram_addr_o); end
    step();
    vectors++; if ({sharers_v_o, hits, ways, states} !== {1'b1, ha, wa, sa}) begin miscompares++; $display("FAIL b2b_first got v=%b h=%b w=%h s=%h exp v=1 h=%b w=%h s=%h", sharers_v_o, hits, ways, states, ha, wa, sa); end
    cur_tag = 12'h2AA;
    step();
    v_i = 1'b0;
    vectors++; if ({sharers_v_o, ram_v_o, ram_addr_o} !== {2'b01, 5'h12}) begin miscompares++; $display("FAIL b2b_accept got sv=%b rv=%b a=%h exp sv=0 rv=1 a=12", sharers_v_o, ram_v_o, ram_addr_o); end
    repeat (3) step();
    vectors++; if ({sharers_v_o, hits, ways, states} !== {1'b1, hb, wb, sb}) begin miscompares++; $display("FAIL b2b_second got v=%b h=%b w=%h s=%h exp v=1 h=%b w=%h s=%h", sharers_v_o, hits, ways, states, hb, wb, sb); end
  endtask

  task automatic test_abort();
    for (int a = 0; a < 32; a++)
      for (int e = 0; e < 16; e++) mem[a][e*15 +: 15] = {12'h0C3, 3'd6};
    issue(4'd4, 12'h0C3);
    step();
    reset_i = 1'b0;
    step();
    reset_i = 1'b1;
    vectors++; if ({ready_o, ram_v_o, sharers_v_o, ram_addr_o} !== 8'b100_00000) begin miscompares++; $display("FAIL abort_state got rdy=%b rv=%b sv=%b a=%h exp 1 0 0 00", ready_o, ram_v_o, sharers_v_o, ram_addr_o); end
    step();
    vectors++; if ({ready_o, sharers_v_o, hits, ways, states} !== {2'b10, 28'h0}) begin miscompares++; $display("FAIL abort_discard got rdy=%b sv=%b h=%b w=%h s=%h exp rdy=1 rest 0", ready_o, sharers_v_o, hits, ways, states); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      logic [3:0] wg, eh;
      logic [11:0] tg, ew, es;
      int lat;
      wg = 4'($urandom);
      tg = 12'($urandom);
      randomize_wg(wg, tg);
      model(wg, tg, eh, ew, es);
      issue(wg, tg);
      lat = 1;
      while (!sharers_v_o && lat < 10) begin
        step();
        lat++;
      end
      vectors++; if (lat != 4) begin miscompares++; $display("FAIL rand_latency it=%0d got %0d exp 4", it, lat); end
      vectors++; if ({hits, ways, states} !== {eh, ew, es}) begin miscompares++; $display("FAIL rand_result it=%0d got h=%b w=%h s=%h exp h=%b w=%h s=%h", it, hits, ways, states, eh, ew, es); end
      repeat ($urandom_range(0, 2)) step();
      vectors++; if ({sharers_v_o, hits, ways, states} !== {1'b1, eh, ew, es}) begin miscompares++; $display("FAIL rand_hold it=%0d got v=%b h=%b w=%h s=%h", it, sharers_v_o, hits, ways, states); end
    end
  endtask

  initial begin
    fill_invalid();
    @(posedge clk);
    #1;
    test_reset();
    test_single_hit();
    test_multi_hit();
    test_invalid();
    test_back_to_back();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/bp_cce_dir_sharers_gen.md
BP_CCE_DIR_SHARERS_GEN -- requirements
Module: bp_cce_dir_sharers_gen

Interface
REQ-001 Param num_lce_p, "inv", number of LCEs tracked per way-group.
REQ-002 Param lce_assoc_p, "inv", max LCE associativity (ways per LCE tag set).
REQ-003 Param lce_per_row_p, "inv", LCE tag sets per directory RAM row; num_lce_p SHALL be a multiple of it.
REQ-004 Param tag_width_p, "inv", directory tag width; derived rows_lp = num_lce_p/lce_per_row_p, lg_lce_assoc_lp = BSG_SAFE_CLOG2(lce_assoc_p).
REQ-005 Param wg_width_p, "inv", way-group index width; ram_addr_width_lp = wg_width_p + BSG_SAFE_CLOG2(rows_lp).
REQ-006 clk_i  in  1  sole clock.
REQ-007 reset_i  in  1  synchronous, active-low reset (0 = reset).
REQ-008 v_i  in  1  lookup request valid.
REQ-009 ready_o  out  1  lookup request accepted when v_i & ready_o.
REQ-010 wg_i  in  wg_width_p  way-group to scan.
REQ-011 tag_i  in  tag_width_p  target tag.
REQ-012 ram_v_o  out  1  directory RAM read strobe.
REQ-013 ram_addr_o  out  ram_addr_width_lp  = {wg, row}.
REQ-014 ram_data_i  in  lce_per_row_p*lce_assoc_p*(tag_width_p+$bits(bp_coh_states_e))  row data, valid exactly 1 cycle after ram_v_o; entry {tag, state}, LCE-major then way.
REQ-015 sharers_v_o  out  1  sharers vectors valid.
REQ-016 sharers_hits_o  out  num_lce_p  per-LCE hit.
REQ-017 sharers_ways_o  out  num_lce_p*lg_lce_assoc_lp  per-LCE hit way.
REQ-018 sharers_coh_states_o  out  num_lce_p*bp_coh_states_e  per-LCE hit state.

Function
REQ-019 FSM states e_idle, e_read, e_done; reset -> e_idle.
REQ-020 ready_o SHALL be 1 in e_idle and e_done, 0 in e_read.
REQ-021 Accept (cycle 0): latch wg_i/tag_i, clear hits/ways/states to 0, drop sharers_v_o next cycle, go to e_read.
REQ-022 e_read: ram_v_o=1 on cycles 1..rows_lp, row counter 0..rows_lp-1, ram_addr_o={latched wg, row}; one row per cycle, no bubbles.
REQ-023 Data for row r (arriving cycle r+2) SHALL update LCEs r*lce_per_row_p .. (r+1)*lce_per_row_p-1 only.
REQ-024 Way hit = stored tag == latched tag AND state != e_COH_I.
REQ-025 LCE hit = OR of way hits; way = lowest-index hitting way (multiple hits: lowest wins); state = that way's state; no hit -> way 0, state e_COH_I.
REQ-026 After last row data captured (cycle rows_lp+1) go to e_done; sharers_v_o=1 from cycle rows_lp+2, outputs held stable until next accept.
REQ-027 Total latency accept -> sharers_v_o = rows_lp+2 cycles.
REQ-028 Accept in e_done is legal back-to-back; v_i in e_read is ignored (no queueing).
REQ-029 Outputs registered; no combinational path from ram_data_i or v_i to any output except none (ready_o from state only).
REQ-030 ram_data_i ignored in any cycle not 1 after ram_v_o.

Reset
REQ-031 Reset values: ready_o=1, ram_v_o=0, ram_addr_o=0, sharers_v_o=0, hits/ways/states all 0.
REQ-032 Reset mid-e_read SHALL abort: next cycle e_idle, ram_v_o=0, in-flight RAM data discarded.

Structure
REQ-033 bp_coh_states_e and e_COH_I come from bp_common_pkg; FSM state enum bp_cce_dir_sharers_gen_state_e goes in bp_cce_pkg.
REQ-034 One sub-module: per-LCE way matcher using bsg_priority_encode (lo_to_hi) over way hits, instantiated lce_per_row_p times.
REQ-035 Outputs drive bp_cce_gad sharers_* inputs directly, no glue.

Verification (num_lce_p=4, lce_assoc_p=8, lce_per_row_p=2, rows_lp=2)
REQ-036 Reset, then wg_i=5, tag_i=0x1A, LCE1 way3=(0x1A,e_COH_S), rest invalid -> ram_addr_o 0xA then 0xB, sharers_v_o at cycle 4, hits=0010, way[1]=3, state[1]=S.
REQ-037 Tag 0x1A in LCE2 ways 2 and 6 (M, S) -> hits=0100, way[2]=2, state[2]=M.
REQ-038 Matching tag but state e_COH_I in all LCEs -> hits=0000, all ways 0, states I.
REQ-039 Back-to-back: second v_i in e_done cycle of first -> accepted, sharers_v_o low next cycle, second result at +4 cycles; v_i during e_read -> ready_o=0, ignored.
REQ-040 reset_i=0 during cycle 2 of a scan -> next cycle ready_o=1, ram_v_o=0, sharers_v_o=0, stale ram_data_i not captured.
